btb_port_scheduler: RTL

//  Owns the single read/write port of a direct-mapped BTB array. Arbitrates fetch-side lookups against

---
 rtl/btb_port_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/btb_port_scheduler.sv
// btb_port_scheduler: owns the single read/write port of a direct-mapped BTB.
// Fetch lookups compete with buffered commit updates for the port; a
// starvation counter forces an update through after a run of fetch wins.
// After reset and on flush_req the whole table is invalidated by a walk
// that writes zero to every entry, one entry per cycle.
module btb_port_scheduler #(
  parameter int BTB_DEPTH    = 32,
  parameter int BTB_IDX_W    = 5,
  parameter int UPD_DEPTH    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic [BTB_IDX_W-1:0] fetch_idx,
  output logic                 fetch_gnt,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  input  logic                 upd_taken,
  output logic                 upd_ready,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 btb_en,
  output logic                 btb_we,
  output logic [BTB_IDX_W-1:0] btb_addr,
  output logic [65:0]          btb_wdata
);

  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [BTB_IDX_W-1:0] WALK_LAST = BTB_IDX_W'(BTB_DEPTH - 1);
  localparam logic [CNT_W-1:0]     FIFO_CAP  = CNT_W'(UPD_DEPTH);
  localparam logic [STV_W-1:0]     STV_MAX   = STV_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_WALK,
    ST_RUN
  } state_t;

  state_t               state;
  logic [BTB_IDX_W-1:0] walk_idx;
  logic [STV_W-1:0]     starve_cnt;

  // Commit-update FIFO storage and bookkeeping
  logic [31:0]          fifo_pc    [UPD_DEPTH];
  logic [31:0]          fifo_tgt   [UPD_DEPTH];
  logic                 fifo_taken [UPD_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;

  logic fifo_empty;
  logic fifo_full;
  logic force_upd;
  logic run_arb;
  logic fetch_win;
  logic pop;
  logic push;

  // Arbitration decisions for the current cycle
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FIFO_CAP);
    force_upd  = !fifo_empty && (starve_cnt == STV_MAX);
    run_arb    = rst && (state == ST_RUN) && !flush_req;
    fetch_win  = run_arb && fetch_req && !force_upd;
    pop        = run_arb && !fetch_win && !fifo_empty;
    upd_ready  = run_arb && !fifo_full;
    push       = upd_valid && upd_ready;
  end

  // Port drive: walk write, fetch read, or FIFO head write
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    fetch_gnt  = 1'b0;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    btb_en     = 1'b0;
    btb_we     = 1'b0;
    btb_addr   = '0;
    btb_wdata  = '0;
    if (rst) begin
      if (state == ST_WALK) begin
        btb_en     = 1'b1;
        btb_we     = 1'b1;
        btb_addr   = walk_idx;
        flush_busy = 1'b1;
        flush_done = (walk_idx == WALK_LAST);
      end else if (fetch_win) begin
        fetch_gnt = 1'b1;
        btb_en    = 1'b1;
        btb_addr  = fetch_idx;
      end else if (pop) begin
        btb_en    = 1'b1;
        btb_we    = 1'b1;
        btb_addr  = fifo_pc[rd_ptr][BTB_IDX_W+1:2];
        btb_wdata = {1'b1, fifo_pc[rd_ptr], fifo_tgt[rd_ptr], fifo_taken[rd_ptr]};
      end
    end
  end

  // FIFO payload write on accepted update
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; only the pointers and count define which entries are live.
    if (push) begin
      fifo_pc[wr_ptr]    <= upd_pc;
      fifo_tgt[wr_ptr]   <= upd_target;
      fifo_taken[wr_ptr] <= upd_taken;
    end
  end

  // Control FSM: walk sequencing, FIFO pointers and starvation counter
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      state      <= ST_WALK;
      walk_idx   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_WALK: begin
          walk_idx <= walk_idx + 1'b1;
          if (walk_idx == WALK_LAST) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush_req) begin
            state      <= ST_WALK;
            walk_idx   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
          end else begin
            if (push) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
              2'b10:   count <= count + 1'b1;
              2'b01:   count <= count - 1'b1;
              default: count <= count;
            endcase
            if (fetch_win && !fifo_empty) begin
              if (starve_cnt != STV_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        default: state <= ST_WALK;
      endcase
    end
  end

endmodule
